instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction decoder.
- Keeps the PC and issues word fetches to instruction memory over a valid/ready request channel, then accepts in-order responses.
- Buffers fetched words in a small FIFO and presents {Instruction, PC} to decode with a valid/ready handshake.
- Handles redirects (branch/jump) from execute by flushing buffered words and discarding stale in-flight responses.

---
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: keeps the PC, issues credit-limited imem requests, buffers in-order responses for decode.
// Build option FETCH_MISALIGN_CHECK_EN: a misaligned redirect raises a sticky flag and halts fetching.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instruction,
  output logic [31:0] instr_pc,
  output logic        fetch_misaligned
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_BOOT, S_RUN} state_t;
`endif

  state_t           state_reg;
  logic [31:0]      pc_reg;
  logic [31:0]      rsp_pc_reg;
  logic [CNT_W-1:0] outstanding_reg;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [63:0]      fifo_mem [FIFO_DEPTH];

  logic [CNT_W:0]   in_use;
  logic             credit_ok;
  logic             req_fire;
  logic             rsp_fire;
  logic             halt_now;
  logic             halted;
  logic             flush;
  logic             push;
  logic             pop;
  logic [31:0]      redirect_target;
  logic [63:0]      head;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_reg;

  assign halt_now         = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign halted           = (state_reg == S_HALT);
  assign redirect_target  = redirect_pc;
  assign fetch_misaligned = misaligned_reg;
`else
  assign halt_now         = 1'b0;
  assign halted           = 1'b0;
  assign redirect_target  = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_misaligned = 1'b0;
`endif

  // Every request in flight owns a FIFO slot, so a returning word always fits.
  assign in_use         = {1'b0, outstanding_reg} + {1'b0, count_reg};
  assign credit_ok      = in_use < {1'b0, DEPTH_C};
  assign imem_req_valid = (state_reg == S_RUN) && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && (outstanding_reg != '0);

  assign flush = redirect_valid || halted;
  assign push  = rsp_fire && (drop_cnt_reg == '0) && !flush;
  assign pop   = instr_valid && instr_ready && !flush;

  assign head        = fifo_mem[rd_ptr_reg];
  assign instr_valid = (count_reg != '0);
  assign Instruction = instr_valid ? head[63:32] : 32'h0000_0013;
  assign instr_pc    = instr_valid ? head[31:0]  : 32'h0000_0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_BOOT;
      pc_reg          <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_reg  <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (halt_now) begin
        state_reg      <= S_HALT;
        misaligned_reg <= 1'b1;
      end else if (state_reg == S_BOOT) begin
        state_reg <= S_RUN;
      end
`else
      if (state_reg == S_BOOT) state_reg <= S_RUN;
`endif

      outstanding_reg <= outstanding_reg + CNT_W'(req_fire) - CNT_W'(rsp_fire);

      // A response landing in the redirect cycle is already stale, so it is not counted.
      if (redirect_valid)
        drop_cnt_reg <= outstanding_reg - CNT_W'(rsp_fire);
      else if (rsp_fire && (drop_cnt_reg != '0))
        drop_cnt_reg <= drop_cnt_reg - 1'b1;

      if (redirect_valid) begin
        pc_reg     <= redirect_target;
        rsp_pc_reg <= redirect_target;
      end else begin
        if (req_fire) pc_reg     <= pc_reg + 32'd4;
        if (push)     rsp_pc_reg <= rsp_pc_reg + 32'd4;
      end

      if (flush) begin
        count_reg  <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {imem_rsp_data, rsp_pc_reg};
  end

  property p_rsp_has_credit;
    @(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (outstanding_reg != '0);
  endproperty
  a_rsp_has_credit: assert property (p_rsp_has_credit);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: in-order memory model feeds an expected queue,
// a decode monitor pops and compares; directed phases cover reset, stalls and redirects.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instruction;
  logic [31:0] instr_pc;
  logic        fetch_misaligned;

  instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .Instruction      (Instruction),
    .instr_pc         (instr_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          accept_cnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] pend_q[$];
  logic        mem_ready_en = 1'b1;
  logic        mem_rsp_hold = 1'b0;
  logic [31:0] exp_fetch_pc = RST_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_instr(input string name, input logic [31:0] exp_pc);
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    if (!instr_valid) begin
      n_checks++;
      $display("FAIL %s: instr_valid never rose, expected pc %h", name, exp_pc);
    end else begin
      check32(name, instr_pc, exp_pc);
    end
  endtask

  // Memory model: accepts on valid&&ready, answers in order one cycle later unless held.
  initial begin
    logic [31:0] a;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (!rst_n) begin
        pend_q.delete();
        exp_fetch_pc   = RST_PC;
        imem_req_ready = 1'b0;
      end else begin
        if (!mem_rsp_hold && pend_q.size() > 0) begin
          a = pend_q.pop_front();
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(a);
        end
        if (redirect_valid) exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
        imem_req_ready = mem_ready_en;
        if (imem_req_valid && imem_req_ready) begin
          $display("accept  addr=%h expected=%h", imem_req_addr, exp_fetch_pc);
          check32("fetch_addr", imem_req_addr, exp_fetch_pc);
          pend_q.push_back(imem_req_addr);
          exp_q.push_back({mem_word(exp_fetch_pc), exp_fetch_pc});
          exp_fetch_pc = exp_fetch_pc + 32'd4;
          accept_cnt++;
        end
      end
    end
  end

  // Decode monitor: a redirect discards everything fetched so far, including a same-cycle pop.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n || redirect_valid) begin
        exp_q.delete();
      end else if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL decode_unexpected: got pc %h instr %h, expected nothing", instr_pc, Instruction);
        end else begin
          e = exp_q.pop_front();
          $display("decode  pc=%h instr=%h expected pc=%h instr=%h", instr_pc, Instruction, e[31:0], e[63:32]);
          check32("decode_pc", instr_pc, e[31:0]);
          check32("decode_instr", Instruction, e[63:32]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc0;
    logic [31:0] e0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) step();

    // Reset state
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check1("rst_instr_valid", instr_valid, 1'b0);
    check1("rst_misaligned", fetch_misaligned, 1'b0);
    check32("rst_nop", Instruction, 32'h0000_0013);
    check32("rst_instr_pc", instr_pc, 32'h0);
    check32("rst_req_addr", imem_req_addr, RST_PC);

    // Boot: one idle cycle, then back-to-back requests from RESET_PC
    rst_n = 1'b1;
    #1;
    check1("boot_idle", imem_req_valid, 1'b0);
    step();
    check1("first_req_valid", imem_req_valid, 1'b1);
    check32("first_req_addr", imem_req_addr, 32'h0000_0100);
    step();
    check1("second_req_valid", imem_req_valid, 1'b1);
    check32("second_req_addr", imem_req_addr, 32'h0000_0104);
    check1("no_instr_yet", instr_valid, 1'b0);
    step();
    check1("first_instr_valid", instr_valid, 1'b1);
    check32("first_instr_pc", instr_pc, 32'h0000_0100);
    repeat (6) step();

    // Decode stall: credits cap accepted requests at FIFO_DEPTH
    instr_ready = 1'b0;
    acc0 = accept_cnt;
    repeat (6) step();
    check1("stall_accepts_le_depth", (accept_cnt - acc0) <= 2, 1'b1);
    check1("stall_no_req", imem_req_valid, 1'b0);
    check1("stall_instr_valid", instr_valid, 1'b1);
    step();
    check1("stall_no_req_2", imem_req_valid, 1'b0);
    instr_ready = 1'b1;
    repeat (8) step();

    // Redirect with two requests outstanding
    mem_rsp_hold = 1'b1;
    repeat (4) step();
    check1("credit_full_no_req", imem_req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    #1;
    check1("redirect_no_req", imem_req_valid, 1'b0);
    step();
    redirect_valid = 1'b0;
    mem_rsp_hold   = 1'b0;
    #1;
    check1("redirect_flushed", instr_valid, 1'b0);
    check32("redirect_pc_loaded", imem_req_addr, 32'h0000_2000);
    wait_instr("redirect_first_pc", 32'h0000_2000);
    repeat (6) step();

    // Redirect coinciding with a response and a decode pop
    mem_rsp_hold = 1'b1;
    repeat (4) step();
    instr_ready  = 1'b0;
    mem_rsp_hold = 1'b0;
    step();
    check1("pre_redirect_valid", instr_valid, 1'b1);
    check1("pre_redirect_no_req", imem_req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3000;
    instr_ready    = 1'b1;
    #1;
    check1("redirect2_rsp_present", imem_rsp_valid, 1'b1);
    step();
    redirect_valid = 1'b0;
    #1;
    check1("redirect2_flushed", instr_valid, 1'b0);
    check1("redirect2_req_valid", imem_req_valid, 1'b1);
    check32("redirect2_req_addr", imem_req_addr, 32'h0000_3000);
    wait_instr("redirect2_first_pc", 32'h0000_3000);
    repeat (4) step();

    // Memory back-pressure: address holds, then advances by exactly 4
    mem_ready_en = 1'b0;
    repeat (3) step();
    e0 = exp_fetch_pc;
    repeat (5) begin
      step();
      check1("backpressure_valid", imem_req_valid, 1'b1);
      check32("backpressure_addr", imem_req_addr, e0);
    end
    mem_ready_en = 1'b1;
    step();
    check32("accept_advance", imem_req_addr, e0 + 32'd4);
    repeat (4) step();

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2002;
    step();
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    acc0 = accept_cnt;
    check1("misalign_flag", fetch_misaligned, 1'b1);
    repeat (4) step();
    check1("halt_no_req", imem_req_valid, 1'b0);
    check1("halt_flushed", instr_valid, 1'b0);
    check1("halt_flag_sticky", fetch_misaligned, 1'b1);
    check32("halt_no_accepts", 32'(accept_cnt - acc0), 32'd0);
    rst_n = 1'b0;
    #1;
    check1("reset_clears_flag", fetch_misaligned, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check1("restart_req_valid", imem_req_valid, 1'b1);
    check32("restart_req_addr", imem_req_addr, RST_PC);
`else
    check1("misalign_flag_tied", fetch_misaligned, 1'b0);
    check32("misalign_pc_aligned", imem_req_addr, 32'h0000_2000);
    wait_instr("misalign_first_pc", 32'h0000_2000);
`endif
    repeat (4) step();

    // Drain: everything accepted must have reached decode
    mem_ready_en = 1'b0;
    repeat (8) step();
    check32("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
